// File: rtl/led_controller_if.sv
// Panel-side scan signals produced by the LED controller and consumed by the panel/framebuffer.
interface led_controller_if #(
    parameter int COL_W = 6,
    parameter int ROW_W = 5
);
    logic [ROW_W-1:0] row_addr;
    logic [COL_W-1:0] col_addr;
    logic             oe;
    logic             latch;
    logic             display_clk;

    modport master (
        output row_addr,
        output col_addr,
        output oe,
        output latch,
        output display_clk
    );

    modport slave (
        input row_addr,
        input col_addr,
        input oe,
        input latch,
        input display_clk
    );
endinterface

// File: rtl/led_controller.sv
// HUB-style panel scanner: SHIFT (4 clk per column) -> LATCH -> DISPLAY per row, free running.
// All outputs registered; no backpressure, the scan never stalls.
module led_controller #(
    parameter int COLS         = 64,
    parameter int ROWS         = 32,
    parameter int LATCH_CYCLES = 2,
    parameter int ON_CYCLES    = 256
) (
    input  logic              clk,
    input  logic              rst,
    led_controller_if.master  bus
);
    localparam int COL_W        = $clog2(COLS);
    localparam int ROW_W        = $clog2(ROWS);
    localparam int SHIFT_CYCLES = COLS * 4;
    localparam int MAX_A        = (SHIFT_CYCLES > LATCH_CYCLES) ? SHIFT_CYCLES : LATCH_CYCLES;
    localparam int MAX_PHASE    = (MAX_A > ON_CYCLES) ? MAX_A : ON_CYCLES;
    localparam int CNT_W        = $clog2(MAX_PHASE) + 1;

    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(SHIFT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);

    typedef enum logic [1:0] {
        SHIFT   = 2'd0,
        LATCH   = 2'd1,
        DISPLAY = 2'd2
    } state_t;

    // state/cnt/row describe the cycle the *next* edge will present, so every
    // output is a plain register and cycle 0 appears on the first edge after reset.
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [ROW_W-1:0] row;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= SHIFT;
            cnt             <= '0;
            row             <= '0;
            bus.row_addr    <= '0;
            bus.col_addr    <= '0;
            bus.oe          <= 1'b1;
            bus.latch       <= 1'b0;
            bus.display_clk <= 1'b0;
        end else begin
            bus.row_addr <= row;
            case (state)
                SHIFT: begin
                    // Column address leads the clock rise by two cycles to cover the
                    // framebuffer's registered read latency plus a full cycle of setup.
                    bus.oe          <= 1'b1;
                    bus.latch       <= 1'b0;
                    bus.col_addr    <= cnt[2 +: COL_W];
                    bus.display_clk <= cnt[1];
                    if (cnt == SHIFT_LAST) begin
                        state <= LATCH;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LATCH: begin
                    bus.oe          <= 1'b1;
                    bus.latch       <= 1'b1;
                    bus.col_addr    <= '0;
                    bus.display_clk <= 1'b0;
                    if (cnt == LATCH_LAST) begin
                        state <= DISPLAY;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DISPLAY: begin
                    bus.oe          <= 1'b0;
                    bus.latch       <= 1'b0;
                    bus.col_addr    <= '0;
                    bus.display_clk <= 1'b0;
                    if (cnt == ON_LAST) begin
                        state <= SHIFT;
                        cnt   <= '0;
                        row   <= (row == ROW_LAST) ? '0 : row + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state           <= SHIFT;
                    cnt             <= '0;
                    bus.oe          <= 1'b1;
                    bus.latch       <= 1'b0;
                    bus.col_addr    <= '0;
                    bus.display_clk <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_led_controller.sv
// Directed bench for led_controller: reset, first row timing, row advance, frame wrap, mid-scan reset.
module tb_led_controller;
    localparam int ROW_PERIOD   = 514;
    localparam int FRAME_PERIOD = 32 * ROW_PERIOD;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cyc;

    led_controller_if bus ();

    led_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are sampled 1 ns after the rising edge; cyc is the scan cycle just presented.
    task automatic step();
        @(posedge clk);
        #1;
        cyc = cyc + 1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.row_addr !== 5'd0 || bus.col_addr !== 6'd0 || bus.oe !== 1'b1 ||
                bus.latch !== 1'b0 || bus.display_clk !== 1'b0) begin
                errors++;
                $display("FAIL reset[%0d]: got row=%0d col=%0d oe=%b latch=%b dclk=%b, want row=0 col=0 oe=1 latch=0 dclk=0",
                         i, bus.row_addr, bus.col_addr, bus.oe, bus.latch, bus.display_clk);
            end
        end
    endtask

    // Releases reset and checks row 0's 256 shift cycles.
    task automatic test_first_shift();
        logic       prev_dclk;
        int         rises;
        logic [5:0] exp_col;
        logic       exp_dclk;
        prev_dclk = 1'b0;
        rises     = 0;
        rst       = 1'b0;
        cyc       = -1;
        for (int c = 0; c < 256; c++) begin
            step();
            exp_col  = 6'(c / 4);
            exp_dclk = ((c % 4) >= 2);
            checks++;
            if (bus.col_addr !== exp_col || bus.display_clk !== exp_dclk || bus.oe !== 1'b1 ||
                bus.latch !== 1'b0 || bus.row_addr !== 5'd0) begin
                errors++;
                $display("FAIL shift[cyc %0d]: got col=%0d dclk=%b oe=%b latch=%b row=%0d, want col=%0d dclk=%b oe=1 latch=0 row=0",
                         c, bus.col_addr, bus.display_clk, bus.oe, bus.latch, bus.row_addr, exp_col, exp_dclk);
            end
            if (!prev_dclk && bus.display_clk === 1'b1) begin
                rises++;
                checks++;
                if ((c % 4) != 2) begin
                    errors++;
                    $display("FAIL dclk_rise_pos: got rise at cyc %0d, want cyc%%4==2", c);
                end
            end
            prev_dclk = bus.display_clk;
        end
        checks++;
        if (rises != 64) begin
            errors++;
            $display("FAIL dclk_rise_count: got %0d, want 64", rises);
        end
    endtask

    task automatic test_latch();
        for (int c = 256; c < 258; c++) begin
            step();
            checks++;
            if (bus.latch !== 1'b1 || bus.display_clk !== 1'b0 || bus.oe !== 1'b1 ||
                bus.col_addr !== 6'd0 || bus.row_addr !== 5'd0) begin
                errors++;
                $display("FAIL latch[cyc %0d]: got latch=%b dclk=%b oe=%b col=%0d row=%0d, want latch=1 dclk=0 oe=1 col=0 row=0",
                         c, bus.latch, bus.display_clk, bus.oe, bus.col_addr, bus.row_addr);
            end
        end
    endtask

    task automatic test_display_advance();
        for (int c = 258; c < 514; c++) begin
            step();
            checks++;
            if (bus.oe !== 1'b0 || bus.display_clk !== 1'b0 || bus.latch !== 1'b0 ||
                bus.col_addr !== 6'd0 || bus.row_addr !== 5'd0) begin
                errors++;
                $display("FAIL display[cyc %0d]: got oe=%b dclk=%b latch=%b col=%0d row=%0d, want oe=0 dclk=0 latch=0 col=0 row=0",
                         c, bus.oe, bus.display_clk, bus.latch, bus.col_addr, bus.row_addr);
            end
        end
        step();
        checks++;
        if (bus.oe !== 1'b1 || bus.row_addr !== 5'd1 || bus.col_addr !== 6'd0 ||
            bus.display_clk !== 1'b0 || bus.latch !== 1'b0) begin
            errors++;
            $display("FAIL row_advance[cyc 514]: got oe=%b row=%0d col=%0d dclk=%b latch=%b, want oe=1 row=1 col=0 dclk=0 latch=0",
                     bus.oe, bus.row_addr, bus.col_addr, bus.display_clk, bus.latch);
        end
    endtask

    // Runs through the full frame and on into rows 0-1 of the next, against the row pattern.
    task automatic test_wrap();
        int         p;
        logic [4:0] exp_row;
        logic [5:0] exp_col;
        logic       exp_dclk;
        logic       exp_latch;
        logic       exp_oe;
        while (cyc < FRAME_PERIOD + 2 * ROW_PERIOD - 1) begin
            step();
            p         = cyc % ROW_PERIOD;
            exp_row   = 5'((cyc / ROW_PERIOD) % 32);
            exp_col   = (p < 256) ? 6'(p / 4) : 6'd0;
            exp_dclk  = (p < 256) && ((p % 4) >= 2);
            exp_latch = (p >= 256) && (p < 258);
            exp_oe    = (p < 258);
            checks++;
            if (bus.row_addr !== exp_row || bus.col_addr !== exp_col || bus.display_clk !== exp_dclk ||
                bus.latch !== exp_latch || bus.oe !== exp_oe) begin
                errors++;
                $display("FAIL wrap[cyc %0d]: got row=%0d col=%0d dclk=%b latch=%b oe=%b, want row=%0d col=%0d dclk=%b latch=%b oe=%b",
                         cyc, bus.row_addr, bus.col_addr, bus.display_clk, bus.latch, bus.oe,
                         exp_row, exp_col, exp_dclk, exp_latch, exp_oe);
            end
            if (cyc == FRAME_PERIOD) begin
                checks++;
                if (bus.row_addr !== 5'd0) begin
                    errors++;
                    $display("FAIL wrap_row0: got row=%0d at cyc %0d, want 0", bus.row_addr, cyc);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        // Advance to the middle of row 5's DISPLAY phase.
        while ((cyc % FRAME_PERIOD) != 5 * ROW_PERIOD + 300) step();
        checks++;
        if (bus.oe !== 1'b0 || bus.row_addr !== 5'd5) begin
            errors++;
            $display("FAIL mid_reset_pre: got oe=%b row=%0d, want oe=0 row=5", bus.oe, bus.row_addr);
        end
        rst = 1'b1;
        step();
        checks++;
        if (bus.row_addr !== 5'd0 || bus.oe !== 1'b1 || bus.latch !== 1'b0 ||
            bus.display_clk !== 1'b0 || bus.col_addr !== 6'd0) begin
            errors++;
            $display("FAIL mid_reset: got row=%0d oe=%b latch=%b dclk=%b col=%0d, want row=0 oe=1 latch=0 dclk=0 col=0",
                     bus.row_addr, bus.oe, bus.latch, bus.display_clk, bus.col_addr);
        end
        test_first_shift();
        test_latch();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = -1;
        rst    = 1'b1;
        test_reset();
        test_first_shift();
        test_latch();
        test_display_advance();
        test_wrap();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
